multicycle_control: RTL and testbench

Multicycle successor to the single-cycle main control decoder. A state machine sequences each MIPS instruction over 3–5+ cycles and drives the shared-datapath control signals for PC, IR, memory, register file, ALU-source muxes and ALU Control. It sits between the instruction register (`opcode`/`funct`) and the multicycle datapath. It supports lw, sw, beq, R-type, addi and (optionally) j, and stalls on a memory-ready handshake.

---
 rtl/mc_ctrl_pkg.sv | 68 ++++++
 rtl/mc_ctrl_decode.sv | 84 ++++++++
 rtl/multicycle_control.sv | 97 +++++++++
 tb/tb_multicycle_control.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// datapath mux selects and the bundled control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ASB_B      = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       addi_op;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op, input logic jump_en);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI: return 1'b1;
      OP_J:                                return jump_en;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational output decode: state (plus opcode/funct/rdy where a state
// completes conditionally) to the datapath control word.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter bit SUPPORT_JUMP = 1'b1
) (
  input  state_e      i_state,
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  input  logic        i_rdy,
  output ctrl_t       o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = ASB_FOUR;
        o_ctrl.ir_write  = i_rdy;
        o_ctrl.pc_write  = i_rdy;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b  = ASB_IMM_SH;
        o_ctrl.illegal_op = ~op_supported(i_opcode, SUPPORT_JUMP);
        o_ctrl.instr_done = ~op_supported(i_opcode, SUPPORT_JUMP);
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ASB_IMM;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.i_or_d     = 1'b1;
        o_ctrl.instr_done = i_rdy;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_op     = ALUOP_FUNCT;
        // nop (all-zero R-type) retires here without a writeback cycle
        o_ctrl.instr_done = (i_opcode == OP_R) && (i_funct == 6'h00);
      end
      S_R_WB: begin
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCS_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCS_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ASB_IMM;
        o_ctrl.addi_op   = 1'b1;
      end
      S_ADDI_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.addi_op    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: state register and sequencing; outputs come
// from mc_ctrl_decode. Memory states stall on mem_ready when enabled.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit SUPPORT_JUMP  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       addi_op,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e r_state;
  state_e w_next;
  logic   w_rdy;
  ctrl_t  w_ctrl;

  assign w_rdy = mem_ready | ~USE_MEM_READY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_R:         w_next = S_EXEC_R;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          OP_J:         w_next = SUPPORT_JUMP ? S_JUMP : S_FETCH;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  w_next = (opcode == OP_SW) ? S_MEM_WR
                          : (opcode == OP_LW) ? S_MEM_RD : S_FETCH;
      S_MEM_RD:    w_next = w_rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:    w_next = w_rdy ? S_FETCH : S_MEM_WR;
      S_EXEC_R:    w_next = ((opcode == OP_R) && (funct == 6'h00)) ? S_FETCH : S_R_WB;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      // every retiring state, and the unused encodings, return to FETCH
      default:     w_next = S_FETCH;
    endcase
  end

  mc_ctrl_decode #(.SUPPORT_JUMP(SUPPORT_JUMP)) u_decode (
    .i_state  (r_state),
    .i_opcode (opcode),
    .i_funct  (funct),
    .i_rdy    (w_rdy),
    .o_ctrl   (w_ctrl)
  );

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign ir_write      = w_ctrl.ir_write;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign addi_op       = w_ctrl.addi_op;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;
  assign instr_done    = w_ctrl.instr_done;
  assign illegal_op    = w_ctrl.illegal_op;
  assign state         = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: an instruction-level model expands each instruction into
// its expected per-cycle state/control trace; a monitor compares the DUT.
module tb_multicycle_control;

  typedef struct packed {
    logic pcw, pcwc, irw, iord, mrd, mwr, m2r, rdst, rw, asa, addi;
    logic [1:0] asb, aop, psrc;
    logic done, ill;
  } ctl_t;

  typedef struct {
    logic       rst;
    logic [5:0] opc, fn;
    logic       mr;
    logic [3:0] st;
    ctl_t       c;
  } rec_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_NOP = 3, K_BEQ = 4,
                 K_ADDI = 5, K_J = 6, K_ILL = 7, K_ABORT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = 6'h00, funct = 6'h00;
  logic mem_ready = 1'b0;

  logic d1_pcw, d1_pcwc, d1_irw, d1_iord, d1_mrd, d1_mwr, d1_m2r, d1_rdst, d1_rw, d1_asa, d1_addi;
  logic [1:0] d1_asb, d1_aop, d1_psrc;
  logic d1_done, d1_ill;
  logic [3:0] d1_state;

  logic d2_pcw, d2_pcwc, d2_irw, d2_iord, d2_mrd, d2_mwr, d2_m2r, d2_rdst, d2_rw, d2_asa, d2_addi;
  logic [1:0] d2_asb, d2_aop, d2_psrc;
  logic d2_done, d2_ill;
  logic [3:0] d2_state;

  ctl_t act1;
  assign act1 = {d1_pcw, d1_pcwc, d1_irw, d1_iord, d1_mrd, d1_mwr, d1_m2r, d1_rdst, d1_rw,
                 d1_asa, d1_addi, d1_asb, d1_aop, d1_psrc, d1_done, d1_ill};

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(d1_pcw), .pc_write_cond(d1_pcwc), .ir_write(d1_irw), .i_or_d(d1_iord),
    .mem_read(d1_mrd), .mem_write(d1_mwr), .mem_to_reg(d1_m2r), .reg_dst(d1_rdst),
    .reg_write(d1_rw), .alu_src_a(d1_asa), .addi_op(d1_addi), .alu_src_b(d1_asb),
    .alu_op(d1_aop), .pc_source(d1_psrc), .instr_done(d1_done), .illegal_op(d1_ill),
    .state(d1_state)
  );

  multicycle_control #(.USE_MEM_READY(1'b0), .SUPPORT_JUMP(1'b0)) dut_nj (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(d2_pcw), .pc_write_cond(d2_pcwc), .ir_write(d2_irw), .i_or_d(d2_iord),
    .mem_read(d2_mrd), .mem_write(d2_mwr), .mem_to_reg(d2_m2r), .reg_dst(d2_rdst),
    .reg_write(d2_rw), .alu_src_a(d2_asa), .addi_op(d2_addi), .alu_src_b(d2_asb),
    .alu_op(d2_aop), .pc_source(d2_psrc), .instr_done(d2_done), .illegal_op(d2_ill),
    .state(d2_state)
  );

  rec_t stim_q[$];
  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_rec = 0;
  bit   mon_en = 1'b1;
  logic [5:0] cur_opc, cur_fn;

  function automatic logic rbit();
    return 1'($urandom % 2);
  endfunction

  task automatic push(input logic r, input logic [3:0] st, input ctl_t c, input logic mr);
    rec_t x;
    x.rst = r; x.opc = cur_opc; x.fn = cur_fn; x.mr = mr; x.st = st; x.c = c;
    stim_q.push_back(x);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, starting in FETCH.
  task automatic gen(input int kind, input int sf, input int sm, input int fsel);
    ctl_t c;
    cur_fn = 6'($urandom);
    case (kind)
      K_LW, K_ABORT: cur_opc = 6'h23;
      K_SW:   cur_opc = 6'h2B;
      K_R:    begin cur_opc = 6'h00; cur_fn = (fsel > 0) ? 6'(fsel) : 6'($urandom_range(1, 63)); end
      K_NOP:  begin cur_opc = 6'h00; cur_fn = 6'h00; end
      K_BEQ:  cur_opc = 6'h04;
      K_ADDI: cur_opc = 6'h08;
      K_J:    cur_opc = 6'h02;
      default: begin
        do cur_opc = 6'($urandom);
        while (cur_opc inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02});
      end
    endcase
    for (int i = 0; i < sf; i++) begin
      c = '0; c.mrd = 1; c.asb = 2'b01; push(0, 4'd1, c, 1'b0);
    end
    c = '0; c.mrd = 1; c.asb = 2'b01; c.irw = 1; c.pcw = 1; push(0, 4'd1, c, 1'b1);
    c = '0; c.asb = 2'b11;
    if (kind == K_ILL) begin c.ill = 1; c.done = 1; end
    push(0, 4'd2, c, rbit());
    case (kind)
      K_LW, K_ABORT: begin
        c = '0; c.asa = 1; c.asb = 2'b10; push(0, 4'd3, c, rbit());
        c = '0; c.mrd = 1; c.iord = 1;
        if (kind == K_ABORT) begin
          push(0, 4'd4, c, 1'b0);
          push(1, 4'd0, '0, rbit());
          push(0, 4'd0, '0, rbit());
        end else begin
          for (int i = 0; i < sm; i++) push(0, 4'd4, c, 1'b0);
          push(0, 4'd4, c, 1'b1);
          c = '0; c.rw = 1; c.m2r = 1; c.done = 1; push(0, 4'd5, c, rbit());
        end
      end
      K_SW: begin
        c = '0; c.asa = 1; c.asb = 2'b10; push(0, 4'd3, c, rbit());
        c = '0; c.mwr = 1; c.iord = 1;
        for (int i = 0; i < sm; i++) push(0, 4'd6, c, 1'b0);
        c.done = 1; push(0, 4'd6, c, 1'b1);
      end
      K_R: begin
        c = '0; c.asa = 1; c.aop = 2'b10; push(0, 4'd7, c, rbit());
        c = '0; c.rdst = 1; c.rw = 1; c.done = 1; push(0, 4'd8, c, rbit());
      end
      K_NOP: begin
        c = '0; c.asa = 1; c.aop = 2'b10; c.done = 1; push(0, 4'd7, c, rbit());
      end
      K_BEQ: begin
        c = '0; c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.psrc = 2'b01; c.done = 1;
        push(0, 4'd9, c, rbit());
      end
      K_ADDI: begin
        c = '0; c.asa = 1; c.asb = 2'b10; c.addi = 1; push(0, 4'd11, c, rbit());
        c = '0; c.rw = 1; c.addi = 1; c.done = 1; push(0, 4'd12, c, rbit());
      end
      K_J: begin
        c = '0; c.pcw = 1; c.psrc = 2'b10; c.done = 1; push(0, 4'd10, c, rbit());
      end
      default: ;
    endcase
  endtask

  // Stimulus: apply one record per cycle and hand its expectation to the monitor.
  initial begin
    rec_t r;
    forever begin
      @(posedge clk);
      #2;
      if (stim_q.size() > 0) begin
        r = stim_q.pop_front();
        rst = r.rst; opcode = r.opc; funct = r.fn; mem_ready = r.mr;
        exp_q.push_back(r);
      end
    end
  end

  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_rec++;
        n_cmp += 2;
        if (d1_state !== e.st) begin
          n_err++;
          $display("FAIL state rec%0d: got %0d want %0d", n_rec, d1_state, e.st);
        end
        if (act1 !== e.c) begin
          n_err++;
          $display("FAIL ctrl rec%0d (state %0d): got %05h want %05h", n_rec, e.st, act1, e.c);
        end
      end
    end
  end

  logic [3:0] st2 [9] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
  logic [4:0] k2  [9] = '{5'b00000, 5'b10010, 5'b01100, 5'b10010, 5'b00000,
                          5'b00000, 5'b00010, 5'b00101, 5'b10010};

  initial begin
    int kind, sf, sm;
    logic [4:0] k;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cur_opc = 6'h00; cur_fn = 6'h00;
    push(1, 4'd0, '0, 1'b0);
    push(0, 4'd0, '0, 1'b1);
    gen(K_LW, 0, 0, 0);
    gen(K_SW, 0, 3, 0);
    gen(K_R, 0, 0, 32);
    gen(K_NOP, 0, 0, 0);
    gen(K_BEQ, 0, 0, 0);
    gen(K_J, 0, 0, 0);
    gen(K_ADDI, 0, 0, 0);
    gen(K_ILL, 0, 0, 0);
    gen(K_ABORT, 0, 0, 0);
    gen(K_LW, 2, 2, 0);
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 8);
      sf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      sm = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      gen(kind, sf, sm, 0);
    end
    for (int i = 0; i < 20000 && (stim_q.size() > 0 || exp_q.size() > 0); i++) @(posedge clk);
    if (stim_q.size() > 0 || exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d records left, want 0", stim_q.size() + exp_q.size());
    end
    @(negedge clk);
    mon_en = 1'b0;

    // No-jump, single-cycle-memory variant: j is illegal, mem_ready ignored.
    @(posedge clk); #2; rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (d2_state !== 4'd0) begin
      n_err++; $display("FAIL nj_reset: got %0d want 0", d2_state);
    end
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #2;
      rst = 1'b0; mem_ready = 1'b0; funct = 6'h00;
      opcode = (c < 3) ? 6'h02 : 6'h23;
      @(negedge clk);
      k = {d2_irw, d2_ill, d2_done, d2_mrd, d2_rw};
      n_cmp += 2;
      if (d2_state !== st2[c]) begin
        n_err++; $display("FAIL nj_state c%0d: got %0d want %0d", c, d2_state, st2[c]);
      end
      if (k !== k2[c]) begin
        n_err++; $display("FAIL nj_ctrl c%0d: got %b want %b", c, k, k2[c]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
